csr_reg_bank: RTL and testbench



---
 rtl/csr_reg_bank_if.sv | 22 ++
 rtl/csr_reg_bank.sv | 111 +++++++++++
 tb/tb_csr_reg_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/csr_reg_bank_if.sv
// CSR strobe bus: one-hot per-register write strobes, shared write data,
// and the flattened read bus returned by the register bank.
interface csr_reg_bank_if #(
  parameter int CSR_DATA_BUS_WIDTH   = 32,
  parameter int CSR_STROBE_BUS_WIDTH = 32
);
  logic [CSR_STROBE_BUS_WIDTH-1:0]                    csr_stb_i;
  logic [CSR_DATA_BUS_WIDTH-1:0]                      csr_data_i;
  logic [CSR_DATA_BUS_WIDTH*CSR_STROBE_BUS_WIDTH-1:0] csr_data_o;

  modport master (
    output csr_stb_i,
    output csr_data_i,
    input  csr_data_o
  );

  modport slave (
    input  csr_stb_i,
    input  csr_data_i,
    output csr_data_o
  );
endinterface

// File: rtl/csr_reg_bank.sv
// CSR register bank: CONTROL, W1C STATUS, PULSE, COUNTER, SCRATCH, ID.
// Define CSR_REG_BANK_COUNTER_EN to build the saturating event counter at select 3.
module csr_reg_bank #(
  parameter int                            CSR_DATA_BUS_WIDTH   = 32,
  parameter int                            CSR_STROBE_BUS_WIDTH = 32,
  parameter logic [CSR_DATA_BUS_WIDTH-1:0] ID_VALUE             = 32'hC5C0_0001,
  parameter logic [CSR_DATA_BUS_WIDTH-1:0] CTRL_RESET           = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  csr_reg_bank_if.slave                 bus,
  output logic [CSR_DATA_BUS_WIDTH-1:0] ctrl_o,
  output logic [CSR_DATA_BUS_WIDTH-1:0] pulse_o,
  input  logic [CSR_DATA_BUS_WIDTH-1:0] evt_i,
  input  logic                          cnt_inc_i
);

  localparam int DW = CSR_DATA_BUS_WIDTH;
  localparam int SW = CSR_STROBE_BUS_WIDTH;

  typedef enum int {
    SEL_CONTROL = 0,
    SEL_STATUS  = 1,
    SEL_PULSE   = 2,
    SEL_COUNTER = 3,
    SEL_SCRATCH = 4,
    SEL_ID      = 5
  } csr_sel_e;

  logic [DW-1:0] ctrl_q,    ctrl_d;
  logic [DW-1:0] status_q,  status_d;
  logic [DW-1:0] pulse_q,   pulse_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [DW-1:0] cnt_rd;

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    pulse_d   = '0;
    if (bus.csr_stb_i[SEL_CONTROL]) ctrl_d    = bus.csr_data_i;
    if (bus.csr_stb_i[SEL_SCRATCH]) scratch_d = bus.csr_data_i;
    if (bus.csr_stb_i[SEL_PULSE])   pulse_d   = bus.csr_data_i;
    // Clear first, then OR in events so a same-cycle set beats the W1C.
    status_d = status_q;
    if (bus.csr_stb_i[SEL_STATUS]) status_d = status_q & ~bus.csr_data_i;
    status_d = status_d | evt_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RESET;
      status_q  <= '0;
      pulse_q   <= '0;
      scratch_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      pulse_q   <= pulse_d;
      scratch_q <= scratch_d;
    end
  end

`ifdef CSR_REG_BANK_COUNTER_EN
  logic [DW-1:0] cnt_q, cnt_d;

  // A write clears the counter even when an increment arrives on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.csr_stb_i[SEL_COUNTER]) begin
      cnt_d = '0;
    end else if (cnt_inc_i && (cnt_q != {DW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_rd = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = cnt_inc_i ^ bus.csr_stb_i[SEL_COUNTER];
  assign cnt_rd     = '0;
`endif

  // ID and the unmapped slots ignore their strobes.
  logic unused_stb;
  assign unused_stb = ^bus.csr_stb_i[SW-1:SEL_ID];

  always_comb begin
    bus.csr_data_o                     = '0;
    bus.csr_data_o[SEL_CONTROL*DW +: DW] = ctrl_q;
    bus.csr_data_o[SEL_STATUS*DW  +: DW] = status_q;
    bus.csr_data_o[SEL_COUNTER*DW +: DW] = cnt_rd;
    bus.csr_data_o[SEL_SCRATCH*DW +: DW] = scratch_q;
    bus.csr_data_o[SEL_ID*DW      +: DW] = ID_VALUE;
  end

  assign ctrl_o  = ctrl_q;
  assign pulse_o = pulse_q;

endmodule

// File: tb/tb_csr_reg_bank.sv
// Self-checking bench for csr_reg_bank: table of write/event vectors with a
// scoreboard queue, plus hand sequences for counter, pulse and async reset.
module tb_csr_reg_bank;

  localparam int          DW = 32;
  localparam int          SW = 32;
  localparam logic [31:0] ID = 32'hC5C0_0001;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] ctrl_o;
  logic [DW-1:0] pulse_o;
  logic [DW-1:0] evt_i;
  logic          cnt_inc_i;

  csr_reg_bank_if #(.CSR_DATA_BUS_WIDTH(DW), .CSR_STROBE_BUS_WIDTH(SW)) bus_if ();

  csr_reg_bank #(
    .CSR_DATA_BUS_WIDTH  (DW),
    .CSR_STROBE_BUS_WIDTH(SW),
    .ID_VALUE            (ID),
    .CTRL_RESET          (32'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .ctrl_o   (ctrl_o),
    .pulse_o  (pulse_o),
    .evt_i    (evt_i),
    .cnt_inc_i(cnt_inc_i)
  );

`ifdef CSR_REG_BANK_COUNTER_EN
  // Narrow instance so counter saturation is reachable in a few hundred cycles.
  logic [7:0] sm_ctrl_o, sm_pulse_o, sm_evt_i;
  logic       sm_inc_i;
  csr_reg_bank_if #(.CSR_DATA_BUS_WIDTH(8), .CSR_STROBE_BUS_WIDTH(8)) sm_if ();
  csr_reg_bank #(
    .CSR_DATA_BUS_WIDTH  (8),
    .CSR_STROBE_BUS_WIDTH(8),
    .ID_VALUE            (8'h01),
    .CTRL_RESET          (8'h00)
  ) dut_sm (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (sm_if.slave),
    .ctrl_o   (sm_ctrl_o),
    .pulse_o  (sm_pulse_o),
    .evt_i    (sm_evt_i),
    .cnt_inc_i(sm_inc_i)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] stb;
    logic [31:0] data;
    logic [31:0] evt;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_status;
    logic [31:0] exp_pulse;
    logic [31:0] exp_scratch;
  } vec_t;

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] status;
    logic [31:0] pulse;
    logic [31:0] scratch;
  } exp_t;

  int   checks;
  int   failures;
  vec_t vecs[14];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int k);
    return bus_if.csr_data_o[k*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    cnt_inc_i        = 1'b0;
    evt_i            = '0;
    bus_if.csr_stb_i  = '0;
    bus_if.csr_data_i = '0;
`ifdef CSR_REG_BANK_COUNTER_EN
    sm_inc_i         = 1'b0;
    sm_evt_i         = '0;
    sm_if.csr_stb_i  = '0;
    sm_if.csr_data_i = '0;
`endif

    //          stb                         data          evt           ctrl          status        pulse         scratch
    vecs[0]  = '{32'h0000_0001,             32'hDEAD_BEEF, 32'h0,       32'hDEAD_BEEF, 32'h0,       32'h0,        32'h0};
    vecs[1]  = '{32'h0000_0010,             32'h1234_5678, 32'h0,       32'hDEAD_BEEF, 32'h0,       32'h0,        32'h1234_5678};
    vecs[2]  = '{32'h0000_0020,             32'h0,         32'h0,       32'hDEAD_BEEF, 32'h0,       32'h0,        32'h1234_5678};
    vecs[3]  = '{32'h0,                     32'h0,         32'h5,       32'hDEAD_BEEF, 32'h5,       32'h0,        32'h1234_5678};
    vecs[4]  = '{32'h0000_0002,             32'h1,         32'h0,       32'hDEAD_BEEF, 32'h4,       32'h0,        32'h1234_5678};
    vecs[5]  = '{32'h0000_0002,             32'h4,         32'h4,       32'hDEAD_BEEF, 32'h4,       32'h0,        32'h1234_5678};
    vecs[6]  = '{32'h0000_0002,             32'h4,         32'h0,       32'hDEAD_BEEF, 32'h0,       32'h0,        32'h1234_5678};
    vecs[7]  = '{32'h0000_0004,             32'hA5,        32'h0,       32'hDEAD_BEEF, 32'h0,       32'hA5,       32'h1234_5678};
    vecs[8]  = '{32'h0,                     32'hA5,        32'h0,       32'hDEAD_BEEF, 32'h0,       32'h0,        32'h1234_5678};
    vecs[9]  = '{32'h0000_0004,             32'h11,        32'h0,       32'hDEAD_BEEF, 32'h0,       32'h11,       32'h1234_5678};
    vecs[10] = '{32'h0000_0004,             32'h22,        32'h0,       32'hDEAD_BEEF, 32'h0,       32'h22,       32'h1234_5678};
    vecs[11] = '{32'h0,                     32'h0,         32'h300,     32'hDEAD_BEEF, 32'h300,     32'h0,        32'h1234_5678};
    vecs[12] = '{32'h0000_0017,             32'h0000_0101, 32'h0,       32'h0000_0101, 32'h200,     32'h0000_0101, 32'h0000_0101};
    vecs[13] = '{32'h8000_0040,             32'hFFFF_FFFF, 32'h0,       32'h0000_0101, 32'h200,     32'h0,        32'h0000_0101};

    // Reset state after three cycles of rst_n low.
    repeat (3) @(negedge clk);
    check("rst_ctrl_o", ctrl_o, 32'h0);
    check("rst_pulse_o", pulse_o, 32'h0);
    check("rst_slice5_id", slice(5), ID);
    for (int k = 0; k < SW; k++) begin
      if (k != 5) check($sformatf("rst_slice%0d", k), slice(k), 32'h0);
    end
    rst_n = 1'b1;

    // Table vectors: drive, push expectation, pop after the edge.
    for (int i = 0; i < 14; i++) begin
      bus_if.csr_stb_i  = vecs[i].stb;
      bus_if.csr_data_i = vecs[i].data;
      evt_i             = vecs[i].evt;
      sb_q.push_back('{vecs[i].exp_ctrl, vecs[i].exp_status, vecs[i].exp_pulse, vecs[i].exp_scratch});
      step();
      e = sb_q.pop_front();
      check($sformatf("v%0d_ctrl_o", i),  ctrl_o,   e.ctrl);
      check($sformatf("v%0d_slice0", i),  slice(0), e.ctrl);
      check($sformatf("v%0d_status", i),  slice(1), e.status);
      check($sformatf("v%0d_slice2", i),  slice(2), 32'h0);
      check($sformatf("v%0d_pulse_o", i), pulse_o,  e.pulse);
      check($sformatf("v%0d_slice3", i),  slice(3), 32'h0);
      check($sformatf("v%0d_scratch", i), slice(4), e.scratch);
      check($sformatf("v%0d_slice5", i),  slice(5), ID);
    end
    for (int k = 6; k < SW; k++) check($sformatf("unused_slice%0d", k), slice(k), 32'h0);
    bus_if.csr_stb_i = '0;
    evt_i            = '0;
    step();
    check("pulse_idle", pulse_o, 32'h0);

`ifdef CSR_REG_BANK_COUNTER_EN
    cnt_inc_i = 1'b1;
    repeat (10) step();
    check("cnt_ten", slice(3), 32'd10);
    bus_if.csr_stb_i  = 32'h0000_0008;
    bus_if.csr_data_i = 32'h5555_5555;
    step();
    check("cnt_write_wins", slice(3), 32'h0);
    bus_if.csr_stb_i = '0;
    cnt_inc_i        = 1'b0;
    step();
    check("cnt_hold", slice(3), 32'h0);

    sm_inc_i = 1'b1;
    repeat (254) step();
    check("sm_cnt_fe", {24'h0, sm_if.csr_data_o[3*8 +: 8]}, 32'hFE);
    step();
    check("sm_cnt_ff", {24'h0, sm_if.csr_data_o[3*8 +: 8]}, 32'hFF);
    step();
    check("sm_cnt_sat", {24'h0, sm_if.csr_data_o[3*8 +: 8]}, 32'hFF);
    sm_inc_i = 1'b0;
`else
    cnt_inc_i         = 1'b1;
    bus_if.csr_stb_i  = 32'h0000_0008;
    bus_if.csr_data_i = 32'hFFFF_FFFF;
    step();
    check("nocnt_write", slice(3), 32'h0);
    bus_if.csr_stb_i = '0;
    repeat (3) step();
    check("nocnt_inc", slice(3), 32'h0);
    cnt_inc_i = 1'b0;
`endif

    // Async reset in the middle of a two-strobe write.
    bus_if.csr_stb_i  = 32'h0000_0011;
    bus_if.csr_data_i = 32'h55;
    evt_i             = 32'h8;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl_o", ctrl_o, 32'h0);
    check("async_rst_slice0", slice(0), 32'h0);
    check("async_rst_status", slice(1), 32'h0);
    check("async_rst_slice4", slice(4), 32'h0);
    check("async_rst_slice5", slice(5), ID);
    repeat (2) @(negedge clk);
    check("rst_hold_slice4", slice(4), 32'h0);
    bus_if.csr_data_i = 32'h77;
    evt_i             = '0;
    rst_n             = 1'b1;
    step();
    check("post_rst_slice0", slice(0), 32'h77);
    check("post_rst_slice4", slice(4), 32'h77);
    check("post_rst_ctrl_o", ctrl_o, 32'h77);
    bus_if.csr_stb_i = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
